// File: rtl/blue_pkg.sv
// blue_ctrl shared types: opcodes, instruction field positions, states.
// Also holds the local/ALU instruction classifier used by the sequencer.
package blue_pkg;

  localparam int SEL_HI    = 15;
  localparam int SEL_LO    = 13;
  localparam int LOCAL_BIT = 12;
  localparam int TGT_BIT   = 11;
  localparam int HALT_BIT  = 10;

  typedef enum logic [2:0] {
    OP_ADD,
    OP_SUB,
    OP_OR,
    OP_AND,
    OP_XOR,
    OP_SHR,
    OP_MOV,
    OP_EXCH
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    K_ALU,
    K_LDI,
    K_HALT
  } kind_e;

  function automatic kind_e decode(
    input logic [15:0] ins
  );
    kind_e k;
    if (!ins[LOCAL_BIT])
      k = K_ALU;
    else if (ins[HALT_BIT])
      k = K_HALT;
    else
      k = K_LDI;
    return k;
  endfunction

endpackage

// File: rtl/blue_ctrl_if.sv
// Instruction-memory fetch handshake between blue_ctrl and imem.
// master = sequencer side, slave = memory side.
interface blue_ctrl_if #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 16
);

  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );

endinterface

// File: rtl/blue_ctrl.sv
// Sequencer for the blue ALU: fetch, execute, write back RA/RB.
// LDI and HALT are handled here and never reach the datapath.
module blue_ctrl #(
  parameter int PC_W   = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  blue_ctrl_if.master       imem,
  output logic [DATA_W-1:0] dp_ra,
  output logic [DATA_W-1:0] dp_rb,
  output logic [DATA_W-1:0] dp_ins,
  input  logic [DATA_W-1:0] dp_ra_out,
  input  logic [DATA_W-1:0] dp_rb_out,
  output logic [DATA_W-1:0] ra,
  output logic [DATA_W-1:0] rb,
  output logic              busy,
  output logic              done
);

  import blue_pkg::*;

  state_e            state;
  state_e            state_n;
  kind_e             kind;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] imm;

  assign kind = decode(ir[15:0]);
  assign imm  = {{(DATA_W-8){1'b0}}, ir[7:0]};

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (start) state_n = S_FETCH;
      S_FETCH:
        if (imem.imem_ack) state_n = S_EXEC;
      S_EXEC:
        state_n = (kind == K_HALT) ? S_HALT
                                   : S_FETCH;
      S_HALT:
        if (start) state_n = S_FETCH;
      default:
        state_n = S_IDLE;
    endcase
  end

  always_comb begin
    imem.imem_req = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    unique case (state)
      S_FETCH: begin
        imem.imem_req = 1'b1;
        busy          = 1'b1;
      end
      S_EXEC:  busy = 1'b1;
      S_HALT:  done = 1'b1;
      default: ;
    endcase
  end

  // Only FETCH looks at ack, so an ack without req is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
      ir <= '0;
      ra <= '0;
      rb <= '0;
    end else begin
      if (state == S_FETCH && imem.imem_ack)
        ir <= imem.imem_data;
      if ((state == S_IDLE || state == S_HALT)
          && start)
        pc <= '0;
      if (state == S_EXEC) begin
        unique case (kind)
          K_ALU: begin
            ra <= dp_ra_out;
            rb <= dp_rb_out;
            pc <= pc + PC_W'(1);
          end
          K_LDI: begin
            if (ir[TGT_BIT])
              rb <= imm;
            else
              ra <= imm;
            pc <= pc + PC_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign imem.imem_addr = pc;
  assign dp_ra          = ra;
  assign dp_rb          = rb;
  assign dp_ins         = ir;

endmodule

// File: tb/tb_blue_ctrl.sv
// Self-checking bench for blue_ctrl with a fetch scoreboard
// and a behavioural stand-in for the blue datapath.
module tb_blue_ctrl;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    int          dly;
  } fetch_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] dp_ra, dp_rb, dp_ins;
  logic [15:0] dp_ra_out, dp_rb_out;
  logic [15:0] ra, rb;
  logic        busy, done;

  int     n_cmp = 0;
  int     n_err = 0;
  int     start_pulse_at = -1;
  fetch_t sb[$];

  blue_ctrl_if #(.PC_W(8), .DATA_W(16)) bus ();

  blue_ctrl #(.PC_W(8), .DATA_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .imem      (bus),
    .dp_ra     (dp_ra),
    .dp_rb     (dp_rb),
    .dp_ins    (dp_ins),
    .dp_ra_out (dp_ra_out),
    .dp_rb_out (dp_rb_out),
    .ra        (ra),
    .rb        (rb),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always_comb begin
    dp_ra_out = dp_ra;
    dp_rb_out = dp_rb;
    case (dp_ins[15:13])
      3'd0: dp_ra_out = dp_ra + dp_rb;
      3'd1: dp_ra_out = dp_ra - dp_rb;
      3'd2: dp_ra_out = dp_ra | dp_rb;
      3'd3: dp_ra_out = dp_ra & dp_rb;
      3'd4: dp_ra_out = dp_ra ^ dp_rb;
      3'd5: dp_ra_out = dp_ra >> 1;
      3'd6: dp_ra_out = dp_rb;
      default: begin
        dp_ra_out = dp_rb;
        dp_rb_out = dp_ra;
      end
    endcase
  end

  task automatic push(input logic [7:0] a,
                      input logic [15:0] d,
                      input int w);
    fetch_t f;
    f.addr = a;
    f.data = d;
    f.dly  = w;
    sb.push_back(f);
  endtask

  task automatic run_prog(input int limit,
                          output int cycles);
    fetch_t cur;
    bit     have;
    bit     acked_prev;
    int     waited;
    cycles = 0;
    have = 0;
    acked_prev = 0;
    waited = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!done && cycles < limit) begin
      if (acked_prev) begin
        n_cmp++;
        if (bus.imem_req !== 1'b0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL exec_cycle req=%b busy=%b want req=0 busy=1",
                   bus.imem_req, busy);
        end
      end
      acked_prev = 0;
      bus.imem_ack = 1'b0;
      if (bus.imem_req === 1'b1) begin
        if (!have) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_empty addr=%0d want no fetch",
                     bus.imem_addr);
            break;
          end
          cur = sb.pop_front();
          have = 1;
          waited = 0;
          n_cmp++;
          if (bus.imem_addr !== cur.addr) begin
            n_err++;
            $display("FAIL fetch_addr got=%0d want=%0d",
                     bus.imem_addr, cur.addr);
          end
        end else begin
          n_cmp++;
          if (bus.imem_addr !== cur.addr) begin
            n_err++;
            $display("FAIL addr_stable got=%0d want=%0d",
                     bus.imem_addr, cur.addr);
          end
        end
        if (waited == cur.dly) begin
          bus.imem_ack  = 1'b1;
          bus.imem_data = cur.data;
          have = 0;
          acked_prev = 1;
        end else begin
          waited++;
        end
      end
      if (cycles == start_pulse_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cycles++;
    end
    bus.imem_ack = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || sb.size() != 0) begin
      n_err++;
      $display("FAIL prog_end done=%b left=%0d want done=1 left=0",
               done, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    bus.imem_ack  = 1'b0;
    bus.imem_data = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    n_cmp++;
    if ({bus.imem_req, busy, done} !== 3'b000 ||
        bus.imem_addr !== 8'd0 || ra !== 16'd0 ||
        rb !== 16'd0 || dp_ins !== 16'd0) begin
      n_err++;
      $display("FAIL reset_vals req=%b busy=%b done=%b addr=%0d ra=%h rb=%h ir=%h want all 0",
               bus.imem_req, busy, done, bus.imem_addr, ra, rb, dp_ins);
    end
    bus.imem_ack  = 1'b1;
    bus.imem_data = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus.imem_req !== 1'b0 || dp_ins !== 16'd0 ||
          busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle_hold req=%b ir=%h busy=%b want 0/0000/0",
                 bus.imem_req, dp_ins, busy);
      end
    end
    bus.imem_ack = 1'b0;
  endtask

  task automatic test_program(input int w);
    int cyc;
    push(8'd0, 16'h1003, w);
    push(8'd1, 16'h1804, w);
    push(8'd2, 16'h0000, w);
    push(8'd3, 16'h1400, 0);
    run_prog(200, cyc);
    n_cmp++;
    if (ra !== 16'd7 || rb !== 16'd4 ||
        bus.imem_addr !== 8'd3 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL prog_result ra=%0d rb=%0d pc=%0d busy=%b want 7 4 3 0",
               ra, rb, bus.imem_addr, busy);
    end
    n_cmp++;
    if (cyc != 8 + 3 * w) begin
      n_err++;
      $display("FAIL prog_cycles got=%0d want=%0d", cyc, 8 + 3 * w);
    end
  endtask

  task automatic test_exch;
    int cyc;
    push(8'd0, 16'h1005, 0);
    push(8'd1, 16'h1809, 1);
    push(8'd2, 16'hE000, 0);
    push(8'd3, 16'h1400, 2);
    run_prog(200, cyc);
    n_cmp++;
    if (ra !== 16'd9 || rb !== 16'd5) begin
      n_err++;
      $display("FAIL exch ra=%0d rb=%0d want 9 5", ra, rb);
    end
  endtask

  task automatic test_reset_mid_fetch;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (bus.imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL fetch_entry req=%b want 1", bus.imem_req);
    end
    bus.imem_ack  = 1'b1;
    bus.imem_data = 16'h1003;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.imem_ack = 1'b0;
    n_cmp++;
    if (dp_ins !== 16'd0 || bus.imem_req !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || ra !== 16'd0 ||
        bus.imem_addr !== 8'd0) begin
      n_err++;
      $display("FAIL reset_fetch ir=%h req=%b busy=%b done=%b ra=%h addr=%0d want 0",
               dp_ins, bus.imem_req, busy, done, ra, bus.imem_addr);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.imem_req !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle req=%b busy=%b want 0 0",
               bus.imem_req, busy);
    end
  endtask

  task automatic test_pc_wrap;
    int cyc;
    for (int i = 0; i < 255; i++)
      push(8'(i), 16'h0000, 0);
    push(8'd255, 16'h1001, 0);
    push(8'd0, 16'h1400, 0);
    start_pulse_at = 101;
    run_prog(2000, cyc);
    start_pulse_at = -1;
    n_cmp++;
    if (ra !== 16'd1 || rb !== 16'd0 ||
        bus.imem_addr !== 8'd0) begin
      n_err++;
      $display("FAIL pc_wrap ra=%0d rb=%0d pc=%0d want 1 0 0",
               ra, rb, bus.imem_addr);
    end
    n_cmp++;
    if (cyc != 514) begin
      n_err++;
      $display("FAIL wrap_cycles got=%0d want=514", cyc);
    end
  endtask

  initial begin
    test_reset();
    test_program(0);
    test_program(3);
    test_exch();
    test_reset_mid_fetch();
    test_pc_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/blue_ctrl.md
# blue_ctrl

Sequencing stage directly upstream of the `blue` ALU datapath.

- Fetches 16-bit instructions from an instruction memory over a req/ack handshake.
- Holds the architectural RA/RB registers and the instruction register.
- Presents RA, RB and the instruction to the combinational datapath, then writes RA_OUT/RB_OUT back.
- Decodes load-immediate and halt locally; these are never sent to the datapath as ALU work.

## Interface
Parameters:
- `PC_W`, 8, program counter / instruction address width
- `DATA_W`, 16, register and instruction width

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin execution from pc=0. Sampled only in IDLE or HALT.
- `imem_req` out 1: fetch request.
- `imem_addr` out PC_W: fetch address, equal to pc.
- `imem_ack` in 1: instruction valid. Ignored unless `imem_req`=1.
- `imem_data` in DATA_W: instruction word. Valid when `imem_ack`=1.
- `dp_ra`, `dp_rb`, `dp_ins` out DATA_W: drive datapath RA, RB, ins.
- `dp_ra_out`, `dp_rb_out` in DATA_W: datapath results.
- `ra`, `rb` out DATA_W: architectural registers.
- `busy` out 1: high in FETCH and EXEC.
- `done` out 1: high in HALT.

## Operation
Instruction fields:
- `ins[15:13]` is the ALU select: 000 ADD, 001 SUB, 010 OR, 011 AND, 100 XOR, 101 SHR, 110 MOV, 111 EXCH.
- `ins[12]`=1 marks a local instruction:
  - `ins[10]`=1: HALT.
  - otherwise LDI. Target is RA if `ins[11]`=0, RB if `ins[11]`=1. Value is `{8'h00, ins[7:0]}`.

Datapath drive:
- `dp_ra`=ra, `dp_rb`=rb, `dp_ins`=ir, continuously.

States:
- IDLE
  - `start` → FETCH.
- FETCH
  - `imem_req`=1, `imem_addr`=pc.
  - On a cycle with `imem_ack`=1: ir←`imem_data`, go to EXEC.
- EXEC (exactly one cycle)
  - ALU instruction: ra←`dp_ra_out`, rb←`dp_rb_out`, pc←pc+1, go to FETCH.
  - LDI: load the selected register, leave the other unchanged, pc←pc+1, go to FETCH.
  - HALT: no register write, pc unchanged, go to HALT.
- HALT
  - `start` → pc←0, go to FETCH. ra/rb retained.

Boundary behaviour:
- pc wraps from 2^PC_W−1 to 0 without flagging.
- `start` while busy is ignored.
- `imem_ack` while `imem_req`=0 is ignored.
- `reset` has priority over everything, including mid-fetch: `imem_req` is low on the next cycle and the pending ack is discarded.

## Timing
- Reset values: state IDLE, pc=0, ra=0, rb=0, ir=0, `imem_req`=0, `busy`=0, `done`=0, `imem_addr`=0.
- `imem_req` rises the cycle after `start` is sampled.
- `imem_req` holds, with a stable address, until the ack cycle.
- Zero-wait ack (ack in the first FETCH cycle) is legal.
- `imem_req` is low in the EXEC cycle.
- Minimum of 2 cycles per instruction: FETCH + EXEC.
- Each extra cycle of ack delay adds one cycle.
- Datapath results are captured on the EXEC edge; the datapath is combinational with zero latency.
- `done` rises the cycle after the HALT instruction's EXEC cycle.

## Structure
- Shared package `blue_pkg`:
  - opcode enum (8 ALU codes)
  - field positions (SEL_HI=15, SEL_LO=13, LOCAL_BIT=12, TGT_BIT=11, HALT_BIT=10)
  - state enum (IDLE, FETCH, EXEC, HALT)
- No sub-module. The `blue` datapath is instantiated beside this block at the top level and connected through the `dp_*` ports.

## Test plan
- Reset then idle: all outputs at reset values. `start`=0 for 10 cycles → `imem_req` stays 0.
- Program `1003`, `1804`, `0000`, `1400`, zero-wait ack, datapath ADD returning RA+RB → ra=7, rb=4, `done`=1, pc=3.
- Same program with 3-cycle ack delay → `imem_addr` stable during each wait, identical final ra/rb, 9 extra cycles total.
- EXCH `E000` with ra=5, rb=9 (datapath swaps) → ra=9, rb=5 after EXEC.
- `reset` asserted during FETCH with ack arriving the same cycle → ir=0, state IDLE, `imem_req`=0 next cycle.
- pc=255 executing `1001` → pc=0, next `imem_addr`=0. `start` pulsed mid-run → no effect.
